// File: rtl/rtt_ts_insert_pkg.sv
// Shared definitions for the RTT timestamp insert block and its stats-side peer:
// IOQ header field positions, read-side state encoding and the timestamp word layout.
package rtt_ts_insert_pkg;

    localparam int IOQ_BYTE_LEN_POS = 0;
    localparam int IOQ_WORD_LEN_POS = 48;
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;

    typedef enum logic [2:0] {
        WAIT_HDR  = 3'b001,
        INSERT_TS = 3'b010,
        THRU      = 3'b100
    } rd_state_t;

    typedef enum logic [0:0] {
        TRK_IDLE = 1'b0,
        TRK_BODY = 1'b1
    } trk_state_t;

    typedef struct packed {
        logic [31:0] rsvd;
        logic [31:0] ts;
    } ts_word_t;

    // The stats block subtracts exactly these amounts, so both adds wrap mod 2^16.
    function automatic logic [63:0] ioq_hdr_grow(input logic [63:0] hdr);
        logic [63:0] grown;
        grown = hdr;
        grown[IOQ_BYTE_LEN_POS +: 16] = hdr[IOQ_BYTE_LEN_POS +: 16] + 16'd8;
        grown[IOQ_WORD_LEN_POS +: 16] = hdr[IOQ_WORD_LEN_POS +: 16] + 16'd1;
        return grown;
    endfunction

    function automatic logic [63:0] make_ts_word(input logic [31:0] ts);
        ts_word_t word;
        word.rsvd = 32'h0000_0000;
        word.ts   = ts;
        return word;
    endfunction

endpackage

// File: rtl/rtt_ts_insert_if.sv
// Packet bus between pipeline stages: data/ctrl words with a write strobe and a
// ready signal flowing back from the receiver.
interface rtt_ts_insert_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout whenever
// empty is low, and rd_en consumes it. Synchronous active-high reset.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] NF_LEVEL = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          mem_r [0:DEPTH-1];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
    logic [MAX_DEPTH_BITS:0]   depth_r;

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            depth_r  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   depth_r <= depth_r + 1'b1;
                2'b01:   depth_r <= depth_r - 1'b1;
                default: depth_r <= depth_r;
            endcase
        end
    end

    assign dout        = mem_r[rd_ptr_r];
    assign empty       = (depth_r == '0);
    assign nearly_full = (depth_r >= NF_LEVEL);

endmodule

// File: rtl/rtt_ts_insert_chk.sv
// Simulation checks on the insert block's internal invariants.
module rtt_ts_insert_chk
    import rtt_ts_insert_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input rd_state_t  state,
    input logic       ts_empty,
    input logic       hdr_pop,
    input logic [7:0] hdr_ctrl
);
    // Every queued header owns a timestamp, so one must be waiting when we insert.
    ts_present_a: assert property (@(posedge clk) disable iff (!reset)
        (state == INSERT_TS) |-> !ts_empty);

    hdr_is_ioq_a: assert property (@(posedge clk) disable iff (!reset)
        hdr_pop |-> (hdr_ctrl == IO_QUEUE_STAGE_NUM));
endmodule

// File: rtl/rtt_ts_insert.sv
// Transmit-side RTT stamping: records the ingress time of each packet header and
// inserts it as a 64-bit word right after the IOQ header, growing the lengths.
module rtt_ts_insert
    import rtt_ts_insert_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] TS_CTRL         = 8'h00,
    parameter int                    FIFO_DEPTH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rtt_ts_insert_if.slave       in_bus,
    rtt_ts_insert_if.master      out_bus,
    input  logic [31:0]          timestamp,
    input  logic                 enable,
    output logic [31:0]          pkt_count
);
    trk_state_t trk_r;
    rd_state_t  state_r;

    logic                  fifo_srst_s;
    logic                  ts_wr_s;
    logic                  in_rd_s;
    logic                  ts_rd_s;
    logic                  in_nf_s;
    logic                  in_empty_s;
    logic                  ts_nf_s;
    logic                  ts_empty_s;
    logic [31:0]           ts_head_s;
    logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_head_s;
    logic [CTRL_WIDTH-1:0] head_ctrl_s;
    logic [DATA_WIDTH-1:0] head_data_s;

    logic                  out_wr_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [CTRL_WIDTH-1:0] out_ctrl_r;
    logic [31:0]           pkt_count_r;

    assign fifo_srst_s = !reset;
    // The first word of each packet is the header; its arrival time is the stamp.
    assign ts_wr_s     = in_bus.wr && (trk_r == TRK_IDLE);
    assign head_ctrl_s = in_head_s[DATA_WIDTH +: CTRL_WIDTH];
    assign head_data_s = in_head_s[DATA_WIDTH-1:0];
    assign in_bus.rdy  = !in_nf_s && !ts_nf_s;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .clk         (clk),
        .reset       (fifo_srst_s),
        .din         ({in_bus.ctrl, in_bus.data}),
        .wr_en       (in_bus.wr),
        .rd_en       (in_rd_s),
        .dout        (in_head_s),
        .nearly_full (in_nf_s),
        .empty       (in_empty_s)
    );

    fallthrough_small_fifo #(
        .WIDTH          (32),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_ts_fifo (
        .clk         (clk),
        .reset       (fifo_srst_s),
        .din         (timestamp),
        .wr_en       (ts_wr_s),
        .rd_en       (ts_rd_s),
        .dout        (ts_head_s),
        .nearly_full (ts_nf_s),
        .empty       (ts_empty_s)
    );

    // Write-side packet tracker: finds header words by watching for EOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_r <= TRK_IDLE;
        end else if (in_bus.wr) begin
            case (trk_r)
                TRK_IDLE: trk_r <= TRK_BODY;
                TRK_BODY: trk_r <= (|in_bus.ctrl) ? TRK_IDLE : TRK_BODY;
                default:  trk_r <= TRK_IDLE;
            endcase
        end else begin
            trk_r <= trk_r;
        end
    end

    // FIFO pops for the word the FSM registers on this edge.
    always_comb begin
        in_rd_s = 1'b0;
        ts_rd_s = 1'b0;
        case (state_r)
            WAIT_HDR: begin
                if (out_bus.rdy && !in_empty_s) begin
                    in_rd_s = 1'b1;
                    ts_rd_s = !enable;
                end else begin
                    in_rd_s = 1'b0;
                    ts_rd_s = 1'b0;
                end
            end
            INSERT_TS: begin
                if (out_bus.rdy && !ts_empty_s) begin
                    ts_rd_s = 1'b1;
                end else begin
                    ts_rd_s = 1'b0;
                end
            end
            THRU: begin
                if (out_bus.rdy && !in_empty_s) begin
                    in_rd_s = 1'b1;
                end else begin
                    in_rd_s = 1'b0;
                end
            end
            default: begin
                in_rd_s = 1'b0;
                ts_rd_s = 1'b0;
            end
        endcase
    end

    // Read-side FSM; enable only matters at WAIT_HDR, so it is fixed per packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= WAIT_HDR;
            out_wr_r    <= 1'b0;
            out_data_r  <= '0;
            out_ctrl_r  <= '0;
            pkt_count_r <= 32'd0;
        end else begin
            out_wr_r <= 1'b0;
            case (state_r)
                WAIT_HDR: begin
                    if (in_rd_s) begin
                        out_wr_r   <= 1'b1;
                        out_ctrl_r <= head_ctrl_s;
                        if (enable) begin
                            out_data_r <= ioq_hdr_grow(head_data_s);
                            state_r    <= INSERT_TS;
                        end else begin
                            out_data_r <= head_data_s;
                            state_r    <= THRU;
                        end
                    end
                end
                INSERT_TS: begin
                    if (ts_rd_s) begin
                        out_wr_r    <= 1'b1;
                        out_data_r  <= make_ts_word(ts_head_s);
                        out_ctrl_r  <= TS_CTRL;
                        pkt_count_r <= pkt_count_r + 32'd1;
                        state_r     <= THRU;
                    end
                end
                THRU: begin
                    if (in_rd_s) begin
                        out_wr_r   <= 1'b1;
                        out_data_r <= head_data_s;
                        out_ctrl_r <= head_ctrl_s;
                        if (|head_ctrl_s) begin
                            state_r <= WAIT_HDR;
                        end
                    end
                end
                default: state_r <= WAIT_HDR;
            endcase
        end
    end

    assign out_bus.wr   = out_wr_r;
    assign out_bus.data = out_data_r;
    assign out_bus.ctrl = out_ctrl_r;
    assign pkt_count    = pkt_count_r;

    rtt_ts_insert_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .state    (state_r),
        .ts_empty (ts_empty_s),
        .hdr_pop  ((state_r == WAIT_HDR) && in_rd_s),
        .hdr_ctrl (head_ctrl_s)
    );

endmodule

// File: tb/tb_rtt_ts_insert.sv
// Bench for rtt_ts_insert: a packet-level reference model builds the expected
// output stream per packet; a single process compares every emitted word.
module tb_rtt_ts_insert;

    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] data;
        bit          is_hdr;
        bit          is_ts;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] timestamp;
    logic [31:0] pkt_count;
    logic        enable = 1'b1;
    logic [31:0] ts_base = 32'd0;
    logic [31:0] cyc = 32'd0;
    logic        man_rdy = 1'b1;
    logic        rnd_rdy = 1'b1;
    logic        rand_mode = 1'b0;
    logic        rdy_q = 1'b0;

    rtt_ts_insert_if in_bus ();
    rtt_ts_insert_if out_bus ();

    always #5 clk = ~clk;

    assign timestamp   = ts_base + cyc;
    assign out_bus.rdy = rand_mode ? rnd_rdy : man_rdy;

    always @(negedge clk) cyc <= cyc + 32'd1;
    always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
    always @(posedge clk) rdy_q <= out_bus.rdy;

    rtt_ts_insert dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .timestamp (timestamp),
        .enable    (enable),
        .pkt_count (pkt_count)
    );

    exp_t        exp_q[$];
    logic [71:0] out_log[$];
    int          checks = 0;
    int          failures = 0;
    int          hdrs_out = 0;
    logic [31:0] exp_pkts = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected word)", name);
    endtask

    function automatic logic [71:0] log_at(input int i);
        if (i < out_log.size()) return out_log[i];
        return 'x;
    endfunction

    // Compare every emitted word against the model stream.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_bus.wr) begin
            chk("wr_only_after_rdy", {63'd0, rdy_q}, 64'd1);
            out_log.push_back({out_bus.ctrl, out_bus.data});
            if (exp_q.size() == 0) begin
                note_fail("unexpected_out_word");
            end else begin
                e = exp_q.pop_front();
                if (e.is_ts) exp_pkts = exp_pkts + 32'd1;
                if (e.is_hdr) hdrs_out++;
                chk("out_data", out_bus.data, e.data);
                chk("out_ctrl", {56'd0, out_bus.ctrl}, {56'd0, e.ctrl});
                chk("pkt_count", {32'd0, pkt_count}, {32'd0, exp_pkts});
            end
        end
    end

    task automatic push_exp(input logic [7:0] c, input logic [63:0] d, input bit h, input bit t);
        exp_t e;
        e.ctrl = c; e.data = d; e.is_hdr = h; e.is_ts = t;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 with in_wr left high.
    task automatic send_word(input logic [7:0] c, input logic [63:0] d, input bit force_ts,
                             input logic [31:0] want, output logic [31:0] t_wr);
        int n;
        n = 0;
        while (!in_bus.rdy && n < 500) begin
            in_bus.wr = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) note_fail("in_rdy_timeout");
        if (force_ts) ts_base = want - cyc - 32'd1;
        in_bus.ctrl = c;
        in_bus.data = d;
        in_bus.wr   = 1'b1;
        @(posedge clk);
        t_wr = timestamp;
        #1;
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int ndata, input bit en,
                            input bit force_ts, input logic [31:0] want);
        logic [31:0] t;
        logic [31:0] t_unused;
        logic [63:0] g;
        logic [63:0] d;
        logic [7:0]  c;
        send_word(8'hff, hdr, force_ts, want, t);
        if (en) begin
            g = hdr;
            g[15:0]  = hdr[15:0] + 16'd8;
            g[63:48] = hdr[63:48] + 16'd1;
            push_exp(8'hff, g, 1'b1, 1'b0);
            push_exp(8'h00, {32'd0, t}, 1'b0, 1'b1);
        end else begin
            push_exp(8'hff, hdr, 1'b1, 1'b0);
        end
        for (int i = 0; i < ndata; i++) begin
            d = {$urandom, $urandom};
            c = (i == ndata - 1) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            send_word(c, d, 1'b0, 32'd0, t_unused);
            push_exp(c, d, 1'b0, 1'b0);
        end
        in_bus.wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            note_fail(name);
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hdr_a;
        logic [31:0] t;
        int          n;
        int          hdr_mark;
        bit          low_seen;

        in_bus.wr = 1'b0; in_bus.data = 64'd0; in_bus.ctrl = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_wr", {63'd0, out_bus.wr}, 64'd0);
        chk("reset_pkt_count", {32'd0, pkt_count}, 64'd0);
        chk("reset_in_rdy", {63'd0, in_bus.rdy}, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic stamp with hand-computed output.
        out_log.delete();
        send_pkt({16'd3, 16'h0002, 16'h0001, 16'd24}, 3, 1'b1, 1'b1, 32'h100);
        wait_drain("drain_stamp");
        chk("stamp_len", out_log.size(), 64'd5);
        chk("stamp_byte_len", {48'd0, log_at(0)[15:0]}, 64'd32);
        chk("stamp_word_len", {48'd0, log_at(0)[63:48]}, 64'd4);
        chk("stamp_ports", {32'd0, log_at(0)[47:16]}, 64'h0002_0001);
        chk("stamp_ts_word", log_at(1)[63:0], 64'h0000_0000_0000_0100);
        chk("stamp_ts_ctrl", {56'd0, log_at(1)[71:64]}, 64'd0);
        chk("stamp_pkt_count", {32'd0, pkt_count}, 64'd1);

        // Length fields wrap mod 2^16.
        out_log.delete();
        send_pkt({16'hffff, 32'h0004_0008, 16'hfffc}, 1, 1'b1, 1'b0, 32'd0);
        wait_drain("drain_wrap");
        chk("wrap_byte_len", {48'd0, log_at(0)[15:0]}, 64'h0004);
        chk("wrap_word_len", {48'd0, log_at(0)[63:48]}, 64'h0000);

        // Backpressure: output stalled while time keeps running.
        out_log.delete();
        man_rdy = 1'b0;
        fork
            send_pkt({16'd6, 32'h0001_0001, 16'd48}, 6, 1'b1, 1'b1, 32'h5555);
            begin
                repeat (8) @(posedge clk);
                #2 man_rdy = 1'b1;
            end
        join
        wait_drain("drain_backpressure");
        chk("bp_len", out_log.size(), 64'd8);
        chk("bp_ts_word", log_at(1)[63:0], 64'h5555);

        // Back-to-back single-data-word packets stamped 10..13.
        out_log.delete();
        man_rdy  = 1'b0;
        low_seen = 1'b0;
        fork
            for (int k = 0; k < 4; k++)
                send_pkt({16'd1, 32'h0000_0002, 16'd8}, 1, 1'b1, 1'b1, 32'd10 + 32'(k));
            begin
                repeat (10) begin
                    @(posedge clk); #2;
                    if (!in_bus.rdy) low_seen = 1'b1;
                end
                man_rdy = 1'b1;
            end
        join
        wait_drain("drain_b2b");
        chk("b2b_in_rdy_dropped", {63'd0, low_seen}, 64'd1);
        chk("b2b_len", out_log.size(), 64'd12);
        for (int k = 0; k < 4; k++)
            chk("b2b_ts_word", log_at(3 * k + 1)[63:0], 64'd10 + 64'(k));

        // Bypass packet A, then stamped B with enable toggled mid-packet.
        out_log.delete();
        enable = 1'b0;
        hdr_a = {16'd2, 32'h0003_0004, 16'd16};
        send_pkt(hdr_a, 2, 1'b0, 1'b0, 32'd0);
        wait_drain("drain_bypass_a");
        chk("bypass_len", out_log.size(), 64'd3);
        chk("bypass_hdr", log_at(0)[63:0], hdr_a);
        enable   = 1'b1;
        hdr_mark = hdrs_out;
        fork
            send_pkt({16'd5, 32'h0005_0006, 16'd40}, 5, 1'b1, 1'b0, 32'd0);
            begin
                n = 0;
                while (hdrs_out == hdr_mark && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) note_fail("bypass_b_hdr_timeout");
                enable = 1'b0;
            end
        join
        wait_drain("drain_bypass_b");
        enable = 1'b1;
        chk("bypass_pkt_count", {32'd0, pkt_count}, 64'd8);

        // Reset in the middle of a packet body while words are flowing out.
        send_word(8'hff, {16'd4, 32'h0007_0008, 16'd32}, 1'b0, 32'd0, t);
        push_exp(8'hff, {16'd5, 32'h0007_0008, 16'd40}, 1'b1, 1'b0);
        push_exp(8'h00, {32'd0, t}, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_word(8'h00, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 32'd0, t);
            push_exp(8'h00, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        end
        in_bus.wr = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_out_wr", {63'd0, out_bus.wr}, 64'd0);
        exp_q.delete();
        exp_pkts = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_in_rdy", {63'd0, in_bus.rdy}, 64'd1);
        chk("midreset_pkt_count", {32'd0, pkt_count}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        out_log.delete();
        send_pkt({16'd2, 32'h0009_000a, 16'd16}, 2, 1'b1, 1'b1, 32'h77);
        wait_drain("drain_after_reset");
        chk("after_reset_len", out_log.size(), 64'd4);
        chk("after_reset_ts", log_at(1)[63:0], 64'h77);
        chk("after_reset_pkt_count", {32'd0, pkt_count}, 64'd1);

        // Randomized traffic with random output stalls, both modes.
        rand_mode = 1'b1;
        for (int b = 0; b < 3; b++) begin
            enable = (b != 1);
            for (int p = 0; p < 12; p++)
                send_pkt({$urandom, $urandom}, $urandom_range(1, 6), enable, 1'b0, 32'd0);
            wait_drain("drain_random");
        end
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
